// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared geometry and ctr_word codes for the search-window buffer
package sw_pkg;
  localparam int WORD_WIDTH = 8;
  localparam int WIN_W      = 24;
  localparam int BLK_W      = 16;
  localparam int MAX_DISP   = WIN_W - BLK_W;
  localparam int PTR_W      = 5;

  localparam logic [3:0] CTR_SWAP   = 4'hF;
  localparam logic [3:0] CTR_NOP_LO = 4'h9;
endpackage

// File: rtl/sw_row_bank.sv
// rtl/sw_row_bank.sv - one search-window row of pixel registers with a full flag
module sw_row_bank
  import sw_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we_i,
  input  logic [PTR_W-1:0]            addr_i,
  input  logic [WORD_WIDTH-1:0]       data_i,
  input  logic                        clr_i,
  output logic [WIN_W*WORD_WIDTH-1:0] row_o,
  output logic                        full_o
);
  logic [WIN_W-1:0][WORD_WIDTH-1:0] row_q;
  logic                             full_q;

  // Pixel storage is deliberately not reset; only the full flag qualifies it.
  always_ff @(posedge clk) begin
    if (we_i) begin
      row_q[addr_i] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
    end else if (clr_i) begin
      full_q <= 1'b0;
    end else if (we_i) begin
      if (addr_i == PTR_W'(WIN_W - 1)) begin
        full_q <= 1'b1;
      end else if (full_q) begin
        full_q <= 1'b0;
      end
    end
  end

  assign row_o  = row_q;
  assign full_o = full_q;
endmodule

// File: rtl/search_win_buf.sv
// rtl/search_win_buf.sv - ping-pong search-window row buffer feeding the PE array
module search_win_buf
  import sw_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [3:0]                  ctr_word,
  input  logic                        mem_en_input,
  input  logic                        mem_init_mode,
  input  logic [WORD_WIDTH-1:0]       pix_in,
  input  logic                        pix_in_valid,
  output logic [BLK_W*WORD_WIDTH-1:0] pe_data,
  output logic                        pe_valid,
  output logic                        load_done,
  output logic                        swap_miss,
  output logic                        active_bank
);
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, ptr_eff;
  logic                        act_q, act_d;
  logic                        init_prev_q;
  logic [BLK_W*WORD_WIDTH-1:0] pe_data_q, slice;
  logic                        pe_valid_q, load_done_q, swap_miss_q;

  logic [WIN_W*WORD_WIDTH-1:0] row0, row1, act_row, shifted;
  logic                        full0, full1;
  logic                        run, mode_chg, tgt, shadow_full, act_full;
  logic                        wr_en, wr_last, is_swap, swap_ok, rd_en;
  logic [3:0]                  disp;
  logic [1:0]                  we, clr;

  assign run         = mem_en_input & ~mem_init_mode;
  // Any mode flip restarts the fill pointer so a partial row is abandoned.
  assign mode_chg    = mem_en_input & (mem_init_mode != init_prev_q);
  assign ptr_eff     = mode_chg ? '0 : wr_ptr_q;
  assign tgt         = mem_init_mode ? act_q : ~act_q;
  assign shadow_full = act_q ? full0 : full1;
  assign act_full    = act_q ? full1 : full0;

  assign wr_en   = mem_en_input & pix_in_valid & (mem_init_mode | ~shadow_full);
  assign wr_last = wr_en & (ptr_eff == PTR_W'(WIN_W - 1));
  assign is_swap = run & (ctr_word == CTR_SWAP);
  assign swap_ok = is_swap & shadow_full;
  assign rd_en   = run & (ctr_word < CTR_NOP_LO) & act_full;

  assign we  = {wr_en & tgt, wr_en & ~tgt};
  assign clr = {swap_ok & act_q, swap_ok & ~act_q};

  sw_row_bank u_bank0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (we[0]),
    .addr_i (ptr_eff),
    .data_i (pix_in),
    .clr_i  (clr[0]),
    .row_o  (row0),
    .full_o (full0)
  );

  sw_row_bank u_bank1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (we[1]),
    .addr_i (ptr_eff),
    .data_i (pix_in),
    .clr_i  (clr[1]),
    .row_o  (row1),
    .full_o (full1)
  );

  always_comb begin
    act_row = act_q ? row1 : row0;
    disp    = (ctr_word <= 4'(MAX_DISP)) ? ctr_word : 4'd0;
    shifted = act_row >> (32'(disp) * WORD_WIDTH);
    slice   = shifted[BLK_W*WORD_WIDTH-1:0];
  end

  always_comb begin
    wr_ptr_d = ptr_eff;
    act_d    = act_q;
    if (wr_en) begin
      wr_ptr_d = wr_last ? '0 : ptr_eff + PTR_W'(1);
    end
    if (swap_ok) begin
      wr_ptr_d = '0;
      act_d    = ~act_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      act_q       <= 1'b0;
      init_prev_q <= 1'b1;
      pe_data_q   <= '0;
      pe_valid_q  <= 1'b0;
      load_done_q <= 1'b0;
      swap_miss_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      act_q       <= act_d;
      pe_valid_q  <= rd_en;
      load_done_q <= wr_last;
      swap_miss_q <= is_swap & ~shadow_full;
      if (mem_en_input) begin
        init_prev_q <= mem_init_mode;
      end
      if (rd_en) begin
        pe_data_q <= slice;
      end
    end
  end

  assign pe_data     = pe_data_q;
  assign pe_valid    = pe_valid_q;
  assign load_done   = load_done_q;
  assign swap_miss   = swap_miss_q;
  assign active_bank = act_q;
endmodule

// File: tb/tb_search_win_buf.sv
// tb/tb_search_win_buf.sv - randomized and directed bench against a row-level reference model
module tb_search_win_buf;
  logic         clk;
  logic         rst_n;
  logic [3:0]   ctr_word;
  logic         mem_en_input;
  logic         mem_init_mode;
  logic [7:0]   pix_in;
  logic         pix_in_valid;
  logic [127:0] pe_data;
  logic         pe_valid;
  logic         load_done;
  logic         swap_miss;
  logic         active_bank;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]   m_bank [2][24];
  bit           m_full [2];
  int           m_ptr;
  bit           m_act;
  bit           m_prev;
  logic [127:0] m_data;
  bit           m_valid, m_load, m_miss;

  search_win_buf dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ctr_word      (ctr_word),
    .mem_en_input  (mem_en_input),
    .mem_init_mode (mem_init_mode),
    .pix_in        (pix_in),
    .pix_in_valid  (pix_in_valid),
    .pe_data       (pe_data),
    .pe_valid      (pe_valid),
    .load_done     (load_done),
    .swap_miss     (swap_miss),
    .active_bank   (active_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] lanes(input int base);
    logic [127:0] v;
    for (int k = 0; k < 16; k++) v[k*8 +: 8] = 8'(base + k);
    return v;
  endfunction

  task automatic model(input bit en, input bit init, input int ctr, input bit pv,
                       input logic [7:0] px, input bit rst);
    int  ptr, b;
    bit  s, a, dow;
    if (!rst) begin
      m_ptr = 0; m_full[0] = 0; m_full[1] = 0; m_act = 0; m_prev = 1;
      m_data = '0; m_valid = 0; m_load = 0; m_miss = 0;
      return;
    end
    m_valid = 0; m_load = 0; m_miss = 0;
    if (!en) return;
    ptr = (init != m_prev) ? 0 : m_ptr;
    m_prev = init;
    s = m_full[!m_act];
    a = m_full[m_act];
    b = init ? int'(m_act) : int'(!m_act);
    dow = init ? pv : (pv && !s);
    if (dow) begin
      if (m_full[b]) m_full[b] = 0;
      m_bank[b][ptr] = px;
      ptr++;
      if (ptr == 24) begin
        ptr = 0; m_full[b] = 1; m_load = 1;
      end
    end
    if (!init) begin
      if (ctr <= 8 && a) begin
        for (int k = 0; k < 16; k++) m_data[k*8 +: 8] = m_bank[m_act][ctr + k];
        m_valid = 1;
      end
      if (ctr == 15) begin
        if (s) begin
          m_full[m_act] = 0; m_act = !m_act; ptr = 0;
        end else begin
          m_miss = 1;
        end
      end
    end
    m_ptr = ptr;
  endtask

  task automatic cyc(input bit en, input bit init, input logic [3:0] ctr, input bit pv,
                     input logic [7:0] px, input bit rst);
    rst_n = rst; mem_en_input = en; mem_init_mode = init;
    ctr_word = ctr; pix_in_valid = pv; pix_in = px;
    @(posedge clk);
    model(en, init, int'(ctr), pv, px, rst);
    #1;
    check("pe_valid", 128'(pe_valid), 128'(m_valid));
    check("pe_data", pe_data, m_data);
    check("load_done", 128'(load_done), 128'(m_load));
    check("swap_miss", 128'(swap_miss), 128'(m_miss));
    check("active_bank", 128'(active_bank), 128'(m_act));
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("rst_pe_data", pe_data, 128'd0);

    for (int i = 0; i < 24; i++) cyc(1, 1, 0, 1, 8'(i), 1);
    check("init_load_done", 128'(load_done), 128'd1);
    check("init_bank", 128'(active_bank), 128'd0);

    cyc(1, 0, 4'd3, 0, 0, 1);
    check("disp3", pe_data, lanes(3));
    cyc(1, 0, 4'd8, 0, 0, 1);
    check("disp8", pe_data, lanes(8));
    cyc(1, 0, 4'd10, 0, 0, 1);
    check("nop_hold", pe_data, lanes(8));
    cyc(1, 0, 4'd15, 0, 0, 1);
    check("miss_pulse", 128'(swap_miss), 128'd1);

    for (int i = 0; i < 24; i++) cyc(1, 0, 4'($urandom_range(0, 8)), 1, 8'(100 + i), 1);
    cyc(1, 0, 4'd15, 0, 0, 1);
    check("swap_bank", 128'(active_bank), 128'd1);
    cyc(1, 0, 4'd0, 0, 0, 1);
    check("new_row", pe_data, lanes(100));

    for (int i = 0; i < 23; i++) cyc(1, 0, 4'd0, 1, 8'(50 + i), 1);
    cyc(1, 0, 4'd15, 1, 8'd73, 1);
    check("race_load", 128'(load_done), 128'd1);
    check("race_miss", 128'(swap_miss), 128'd1);
    check("race_bank", 128'(active_bank), 128'd1);
    cyc(1, 0, 4'd15, 0, 0, 1);
    check("race_swap", 128'(active_bank), 128'd0);
    cyc(1, 0, 4'd1, 0, 0, 1);
    check("race_row", pe_data, lanes(51));

    for (int i = 0; i < 10; i++) cyc(1, 0, 4'd0, 1, 8'(i), 1);
    cyc(1, 0, 0, 0, 0, 0);
    check("rst_bank", 128'(active_bank), 128'd0);
    cyc(1, 0, 4'd2, 0, 0, 1);
    check("rst_read", 128'(pe_valid), 128'd0);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
          4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
          8'($urandom), ($urandom_range(0, 199) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
